// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and presents
// {pc+4, instruction, valid} to IF/ID, absorbing memory latency, stalls and redirects.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {StFetch, StBlocked, StDrain} state_e;

  localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'h3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        slot_free;

  assign pc_plus4  = pc_q + 32'd4;
  assign target    = redirect_pc & ~32'h3;
  assign slot_free = !valid_q || !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;
    valid_d     = valid_q;

    if (redirect) begin
      valid_d     = 1'b0;
      inst_out_d  = 32'h0;
      pc_out_d    = 32'h0;
      skid_inst_d = 32'h0;
      skid_pc_d   = 32'h0;
      pc_d        = target;
      // A request still in flight must complete before the new address can be issued.
      if (state_q == StBlocked || imem_ack) begin
        addr_d  = target;
        state_d = StFetch;
      end else begin
        state_d = StDrain;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ack) begin
            pc_d   = pc_plus4;
            addr_d = pc_plus4;
            if (slot_free) begin
              pc_out_d   = pc_plus4;
              inst_out_d = imem_rdata;
              valid_d    = 1'b1;
            end else begin
              skid_pc_d   = pc_plus4;
              skid_inst_d = imem_rdata;
              state_d     = StBlocked;
            end
          end else if (slot_free) begin
            valid_d    = 1'b0;
            inst_out_d = 32'h0;
          end
        end
        StBlocked: begin
          if (!stall) begin
            pc_out_d   = skid_pc_q;
            inst_out_d = skid_inst_q;
            valid_d    = 1'b1;
            state_d    = StFetch;
          end
        end
        StDrain: begin
          if (imem_ack) begin
            addr_d  = pc_q;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= ResetPcAligned;
      addr_q      <= ResetPcAligned;
      skid_inst_q <= 32'h0;
      skid_pc_q   <= 32'h0;
      pc_out_q    <= 32'h0;
      inst_out_q  <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
      valid_q     <= valid_d;
    end
  end

  // Request is suppressed while reset is held so memory never sees a request during reset.
  assign imem_req  = !rst && (state_q != StBlocked);
  assign imem_addr = addr_q;
  assign pc_out    = pc_out_q;
  assign inst_out  = inst_out_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vectors with literal expectations plus a program-order
// scoreboard that checks every consumed instruction and the handshake/hold rules.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] pc2;
  logic [31:0] inst2;
  logic        valid2;

  int unsigned lat;
  logic [7:0]  wait_cnt;
  int          n_pass = 0;
  int          n_total = 0;
  int          consumed = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .valid_out  (valid_out)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .stall      (1'b0),
    .redirect   (1'b0),
    .redirect_pc(32'h0),
    .imem_req   (req2),
    .imem_addr  (addr2),
    .imem_ack   (req2),
    .imem_rdata (addr2),
    .pc_out     (pc2),
    .inst_out   (inst2),
    .valid_out  (valid2)
  );

  // Memory returns the address as data after 'lat' wait cycles.
  assign imem_ack   = imem_req && (32'(wait_cnt) >= lat);
  assign imem_rdata = imem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       wait_cnt <= 8'd0;
    else if (imem_req && imem_ack) wait_cnt <= 8'd0;
    else if (imem_req)             wait_cnt <= wait_cnt + 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: consumed instructions must follow program order from reset/redirect targets.
  initial begin
    logic [31:0] exp_next;
    logic        prev_pend;
    logic [31:0] prev_addr;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    exp_next  = 32'h0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    prev_hold = 1'b0;
    prev_pc   = 32'h0;
    prev_inst = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_next  = 32'h0;
        prev_pend = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_pend) begin
          chk("addr_stable", imem_addr, prev_addr);
          chk("req_held", 32'(imem_req), 32'd1);
        end
        if (prev_hold) begin
          chk("hold_valid", 32'(valid_out), 32'd1);
          chk("hold_pc", pc_out, prev_pc);
          chk("hold_inst", inst_out, prev_inst);
        end
        if (!valid_out) chk("nop_when_invalid", inst_out, 32'h0);
        if (redirect) begin
          exp_next = redirect_pc & ~32'h3;
        end else if (valid_out && !stall) begin
          chk("seq_pc", pc_out, exp_next + 32'd4);
          chk("seq_inst", inst_out, exp_next);
          exp_next = exp_next + 32'd4;
          consumed++;
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
        prev_hold = valid_out && stall && !redirect;
        prev_pc   = pc_out;
        prev_inst = inst_out;
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; lat = 0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst", inst_out, 32'h0);

    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", 32'(valid_out), 32'd0);
    chk("wrap_first_addr", addr2, 32'hFFFF_FFF8);

    tick(); // edge 1
    chk("zw_e1_valid", 32'(valid_out), 32'd1);
    chk("zw_e1_pc", pc_out, 32'd4);
    chk("zw_e1_inst", inst_out, 32'd0);
    chk("zw_e1_addr", imem_addr, 32'd4);
    chk("wrap_e1_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_e1_inst", inst2, 32'hFFFF_FFF8);
    chk("wrap_e1_addr", addr2, 32'hFFFF_FFFC);
    tick(); // edge 2
    chk("zw_e2_pc", pc_out, 32'd8);
    chk("zw_e2_inst", inst_out, 32'd4);
    chk("wrap_e2_pc", pc2, 32'h0);
    chk("wrap_e2_inst", inst2, 32'hFFFF_FFFC);
    chk("wrap_e2_addr", addr2, 32'h0);
    stall = 1'b1;
    tick(); // edge 3
    chk("blk_req", 32'(imem_req), 32'd0);
    chk("blk_pc", pc_out, 32'd8);
    chk("blk_valid", 32'(valid_out), 32'd1);
    chk("wrap_e3_pc", pc2, 32'd4);
    chk("wrap_e3_valid", 32'(valid2), 32'd1);
    tick(); tick(); // edges 4, 5
    stall = 1'b0;
    tick(); // edge 6
    chk("rel_pc", pc_out, 32'd12);
    chk("rel_inst", inst_out, 32'd8);
    tick(); // edge 7
    chk("rel2_pc", pc_out, 32'd16);
    chk("rel2_inst", inst_out, 32'd12);
    lat = 2;
    tick(); // edge 8
    chk("lat_e8_valid", 32'(valid_out), 32'd0);
    chk("lat_e8_addr", imem_addr, 32'd16);
    tick(); // edge 9
    chk("lat_e9_valid", 32'(valid_out), 32'd0);
    chk("lat_e9_addr", imem_addr, 32'd16);
    tick(); // edge 10
    chk("lat_e10_valid", 32'(valid_out), 32'd1);
    chk("lat_e10_pc", pc_out, 32'd20);
    chk("lat_e10_inst", inst_out, 32'd16);
    tick(); // edge 11
    chk("lat_e11_valid", 32'(valid_out), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick(); // edge 12
    redirect = 1'b0;
    chk("drain_valid", 32'(valid_out), 32'd0);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", imem_addr, 32'd20);
    tick(); // edge 13
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", 32'(valid_out), 32'd0);
    tick(); tick(); tick(); // edge 16
    chk("redir_ret_valid", 32'(valid_out), 32'd1);
    chk("redir_ret_pc", pc_out, 32'h104);
    chk("redir_ret_inst", inst_out, 32'h100);
    lat = 0;
    tick(); // edge 17
    chk("e17_pc", pc_out, 32'h108);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick(); // edge 18
    redirect = 1'b0; stall = 1'b0;
    chk("rs_valid", 32'(valid_out), 32'd0);
    chk("rs_inst", inst_out, 32'h0);
    chk("rs_pc", pc_out, 32'h0);
    chk("rs_addr", imem_addr, 32'h200);
    tick(); // edge 19
    chk("rs_ret_valid", 32'(valid_out), 32'd1);
    chk("rs_ret_pc", pc_out, 32'h204);
    chk("rs_ret_inst", inst_out, 32'h200);

    // Mixed traffic: random stalls, redirects and latency, checked by the scoreboard.
    base = consumed;
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(3) == 0);
      redirect    = ($urandom_range(15) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(7) == 0) lat = $urandom_range(2);
      tick();
    end
    stall = 1'b0; redirect = 1'b0;
    tick(); tick();
    chk("mixed_progress", 32'(consumed - base >= 40), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the mips32 pipeline: owns the PC, issues requests to instruction memory over a req/ack handshake, and produces the `{pc+4, instruction, valid}` triple that the IF/ID pipeline register samples. It absorbs variable memory latency, back-pressure from the hazard unit (`stall`) and control-flow redirects from EX (`redirect`), so IF/ID sees either a correct instruction or a NOP bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard unit holds IF/ID; current output must be held
- redirect  in  1  taken branch/jump; flush and refetch from redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- imem_req  out  1  memory request valid
- imem_addr  out  32  word-aligned address of the outstanding request
- imem_ack  in  1  memory response valid; may be high in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- pc_out  out  32  PC+4 of the presented instruction, to IF/ID
- inst_out  out  32  presented instruction; 32'h0 (NOP) when not valid
- valid_out  out  1  pc_out/inst_out hold a real instruction

## Operation
- Output slot = {pc_out, inst_out, valid_out}; consumed at an edge where valid_out=1 and stall=0. Slot free at an edge if valid_out=0 or stall=0.
- Internal: pc (next fetch address), addr (outstanding request address), skid {inst, pc+4}, state.
- States: FETCH, BLOCKED, DRAIN. imem_req=1 in FETCH and DRAIN, 0 in BLOCKED. imem_addr=addr.
- FETCH, ack, slot free: slot <= {pc+4, rdata, 1}; pc, addr <= pc+4; stay FETCH.
- FETCH, ack, slot not free: skid <= {pc+4, rdata}; pc, addr <= pc+4; -> BLOCKED.
- FETCH, no ack, slot free: valid_out <= 0, inst_out <= 0.
- BLOCKED, stall=0: slot <= {skid, 1}; -> FETCH. stall=1: hold everything.
- DRAIN: wait for ack of the stale request; on ack discard rdata, addr <= pc, -> FETCH.
- redirect=1 (priority over stall, ack and all above): valid_out <= 0, inst_out <= 0, pc_out <= 0, skid discarded, pc <= {redirect_pc[31:2], 2'b00}. From FETCH without ack same cycle: -> DRAIN (addr unchanged, request stays up). From FETCH with ack, or from BLOCKED/DRAIN-with-ack: addr <= new pc, -> FETCH (data discarded). DRAIN without ack: stay DRAIN, pc updated.
- Once imem_req=1, imem_addr is stable until imem_ack; requests are never withdrawn.
- pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- rst mid-transaction: all state reset immediately; a response to a pre-reset request arriving after reset is the memory's responsibility (memory is reset too).

## Timing
- Reset values: pc=addr=RESET_PC, state=FETCH, pc_out=0, inst_out=0, valid_out=0, skid=0. imem_req=0 while rst=1; imem_req=1, imem_addr=RESET_PC in first cycle after rst deasserts.
- Zero-wait memory (ack in request cycle): valid_out rises 1 edge after request; sustained 1 instruction/cycle.
- N-cycle memory: valid_out rises on edge N after request; bubbles (valid_out=0) between.
- Redirect to first valid instruction: 1 edge + memory latency, plus remaining stale latency if in DRAIN.
- stall has no effect on slot when valid_out=0 except blocking BLOCKED -> FETCH.

## Test plan
- Reset, zero-wait memory returning addr as data, no stall: imem_addr 0,4,8,…; pc_out 4,8,12… with inst_out 0,4,8… on consecutive cycles, valid_out=1 from cycle 1.
- stall high 3 cycles while slot holds pc_out=8: slot held, next ack goes to skid, imem_req=0 in BLOCKED; after release pc_out=12 then 16, no instruction lost or duplicated.
- 3-cycle memory: imem_addr stable through wait, valid_out pattern 0,0,1 per instruction.
- redirect to 32'h0000_0103 while 3-cycle request outstanding: valid_out=0 next edge, stale data discarded, next request addr 32'h100, pc_out=32'h104 on return.
- redirect and stall same cycle with valid slot: slot flushed (inst_out=0, valid_out=0), fetch resumes at target.
- RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0; pc_out FFFF_FFFC, 0, 4.
